// File: rtl/aes_reg_initiator.sv
// Register-bus initiator that drives one AES-192 job through a memory-mapped AES peripheral:
// it loads plaintext, key and key bank, starts the core, polls for completion, reads the ciphertext and clears the core.
module aes_reg_initiator #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           POLL_LIMIT = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [127:0]            pt_i,
    input  logic [191:0]            key_i,
    input  logic [1:0]              key_sel_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [127:0]            res_data_o,
    output logic [1:0]              res_status_o,
    output logic                    busy_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    write_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    valid_o,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic                    ready_i,
    input  logic                    error_i
);

    localparam int unsigned      CNT_W      = $clog2(POLL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(POLL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(POLL_LIMIT - 1);
    localparam logic [5:0]       IDX_CTRL   = 6'd0;
    localparam logic [5:0]       IDX_STATUS = 6'd11;
    localparam logic [5:0]       IDX_DOUT   = 6'd12;
    localparam logic [5:0]       IDX_KSEL   = 6'd32;
    localparam logic [3:0]       LAST_WRITE = 4'd12;
    localparam logic [3:0]       LAST_READ  = 4'd3;
    localparam logic [1:0]       STAT_OK    = 2'b00;
    localparam logic [1:0]       STAT_BUS   = 2'b01;
    localparam logic [1:0]       STAT_TMO   = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_POLL, S_READ, S_CLEAR, S_RESP} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       step_reg, step_next;
    logic [CNT_W-1:0] poll_cnt_reg, poll_cnt_next;
    logic [127:0]     res_data_reg, res_data_next;
    logic [1:0]       res_status_reg, res_status_next;
    logic [127:0]     pt_reg;
    logic [191:0]     key_reg;
    logic [1:0]       key_sel_reg;
    logic             accept;

    logic [31:0] pt_words  [4];
    logic [31:0] key_words [6];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pt_words
            assign pt_words[gi] = pt_reg[32*gi +: 32];
        end
        for (gi = 0; gi < 6; gi++) begin : g_key_words
            assign key_words[gi] = key_reg[32*gi +: 32];
        end
    endgenerate

    // Bus request is decoded purely from state/step, so it only moves after a completion
    logic [5:0]  word_idx;
    logic        bus_active;
    logic        bus_write;
    logic [31:0] bus_wdata;

    always_comb begin
        word_idx   = IDX_CTRL;
        bus_active = 1'b0;
        bus_write  = 1'b0;
        bus_wdata  = '0;
        case (state_reg)
            S_WRITE: begin
                bus_active = 1'b1;
                bus_write  = 1'b1;
                if (step_reg == 4'd0) begin
                    word_idx = IDX_CTRL;
                end else if (step_reg <= 4'd4) begin
                    word_idx  = {2'b00, step_reg};
                    bus_wdata = pt_words[2'(step_reg - 4'd1)];
                end else if (step_reg <= 4'd10) begin
                    word_idx  = {2'b00, step_reg};
                    bus_wdata = key_words[3'(step_reg - 4'd5)];
                end else if (step_reg == 4'd11) begin
                    word_idx  = IDX_KSEL;
                    bus_wdata = {30'b0, key_sel_reg};
                end else begin
                    word_idx  = IDX_CTRL;
                    bus_wdata = 32'd1;
                end
            end
            S_POLL: begin
                bus_active = 1'b1;
                word_idx   = IDX_STATUS;
            end
            S_READ: begin
                bus_active = 1'b1;
                word_idx   = IDX_DOUT + {4'b0, step_reg[1:0]};
            end
            S_CLEAR: begin
                bus_active = 1'b1;
                bus_write  = 1'b1;
                word_idx   = IDX_CTRL;
            end
            default: ;
        endcase
    end

    wire fire = bus_active && ready_i;

    always_comb begin
        state_next      = state_reg;
        step_next       = step_reg;
        poll_cnt_next   = poll_cnt_reg;
        res_data_next   = res_data_reg;
        res_status_next = res_status_reg;
        accept          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    accept          = 1'b1;
                    state_next      = S_WRITE;
                    step_next       = 4'd0;
                    poll_cnt_next   = '0;
                    res_data_next   = '0;
                    res_status_next = STAT_OK;
                end
            end
            S_RESP: begin
                if (res_ready_i) state_next = S_IDLE;
            end
            default: begin
                if (fire) begin
                    // A bus error ends the job on the spot; no cleanup write is attempted
                    if (error_i) begin
                        state_next      = S_RESP;
                        res_status_next = STAT_BUS;
                    end else begin
                        case (state_reg)
                            S_WRITE: begin
                                if (step_reg == LAST_WRITE) begin
                                    state_next = S_POLL;
                                    step_next  = 4'd0;
                                end else begin
                                    step_next = step_reg + 4'd1;
                                end
                            end
                            S_POLL: begin
                                if (rdata_i[0]) begin
                                    state_next = S_READ;
                                    step_next  = 4'd0;
                                end else begin
                                    if (poll_cnt_reg != CNT_MAX) poll_cnt_next = poll_cnt_reg + CNT_W'(1);
                                    if (poll_cnt_reg >= CNT_LAST) begin
                                        state_next      = S_RESP;
                                        res_status_next = STAT_TMO;
                                    end
                                end
                            end
                            S_READ: begin
                                res_data_next[{step_reg[1:0], 5'b0} +: 32] = rdata_i;
                                if (step_reg == LAST_READ) state_next = S_CLEAR;
                                else                       step_next  = step_reg + 4'd1;
                            end
                            S_CLEAR: begin
                                state_next      = S_RESP;
                                res_status_next = STAT_OK;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= S_IDLE;
            step_reg       <= '0;
            poll_cnt_reg   <= '0;
            res_data_reg   <= '0;
            res_status_reg <= STAT_OK;
            pt_reg         <= '0;
            key_reg        <= '0;
            key_sel_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            step_reg       <= step_next;
            poll_cnt_reg   <= poll_cnt_next;
            res_data_reg   <= res_data_next;
            res_status_reg <= res_status_next;
            if (accept) begin
                pt_reg      <= pt_i;
                key_reg     <= key_i;
                key_sel_reg <= key_sel_i;
            end
        end
    end

    assign cmd_ready_o  = (state_reg == S_IDLE);
    assign busy_o       = (state_reg != S_IDLE);
    assign res_valid_o  = (state_reg == S_RESP);
    assign res_data_o   = res_data_reg;
    assign res_status_o = res_status_reg;
    assign valid_o      = bus_active;
    assign write_o      = bus_write;
    assign wdata_o      = bus_wdata;
    assign wstrb_o      = {(DATA_WIDTH/8){bus_write}};
    assign addr_o       = bus_active ? (BASE_ADDR + (ADDR_WIDTH'(word_idx) << 2)) : '0;

endmodule

// File: tb/tb_aes_reg_initiator.sv
// Directed bench for aes_reg_initiator: a scripted AES register-file responder services the bus,
// with a second instance (POLL_LIMIT = 4) for the poll-timeout case.
module tb_aes_reg_initiator;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         cmd_valid_a, cmd_valid_b;
    logic [127:0] pt;
    logic [191:0] key;
    logic [1:0]   key_sel;
    logic         res_ready;
    logic [31:0]  rdata;
    logic         ready, error;

    logic         a_cmd_ready, a_res_valid, a_busy, a_write, a_valid;
    logic [127:0] a_res_data;
    logic [1:0]   a_res_status;
    logic [31:0]  a_addr, a_wdata;
    logic [3:0]   a_wstrb;
    logic         b_cmd_ready, b_res_valid, b_busy, b_write, b_valid;
    logic [127:0] b_res_data;
    logic [1:0]   b_res_status;
    logic [31:0]  b_addr, b_wdata;
    logic [3:0]   b_wstrb;

    aes_reg_initiator dut (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid_a), .cmd_ready_o(a_cmd_ready),
        .pt_i(pt), .key_i(key), .key_sel_i(key_sel), .res_valid_o(a_res_valid), .res_ready_i(res_ready),
        .res_data_o(a_res_data), .res_status_o(a_res_status), .busy_o(a_busy), .addr_o(a_addr),
        .write_o(a_write), .wdata_o(a_wdata), .wstrb_o(a_wstrb), .valid_o(a_valid),
        .rdata_i(rdata), .ready_i(ready), .error_i(error)
    );

    aes_reg_initiator #(.POLL_LIMIT(4)) dut_lim4 (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid_b), .cmd_ready_o(b_cmd_ready),
        .pt_i(pt), .key_i(key), .key_sel_i(key_sel), .res_valid_o(b_res_valid), .res_ready_i(res_ready),
        .res_data_o(b_res_data), .res_status_o(b_res_status), .busy_o(b_busy), .addr_o(b_addr),
        .write_o(b_write), .wdata_o(b_wdata), .wstrb_o(b_wstrb), .valid_o(b_valid),
        .rdata_i(rdata), .ready_i(ready), .error_i(error)
    );

    logic sel;
    wire         m_cmd_ready  = sel ? b_cmd_ready  : a_cmd_ready;
    wire         m_res_valid  = sel ? b_res_valid  : a_res_valid;
    wire         m_busy       = sel ? b_busy       : a_busy;
    wire         m_write      = sel ? b_write      : a_write;
    wire         m_valid      = sel ? b_valid      : a_valid;
    wire [127:0] m_res_data   = sel ? b_res_data   : a_res_data;
    wire [1:0]   m_res_status = sel ? b_res_status : a_res_status;
    wire [31:0]  m_addr       = sel ? b_addr       : a_addr;
    wire [31:0]  m_wdata      = sel ? b_wdata      : a_wdata;
    wire [3:0]   m_wstrb      = sel ? b_wstrb      : a_wstrb;

    int n_cmp = 0;
    int n_mis = 0;

    int cfg_wait, cfg_poll_ok, cfg_err_addr, cfg_abort_addr;
    logic [64:0]  tr_q[$];
    logic [64:0]  exp_w [13];
    logic [127:0] ct_v;
    int  poll_n, stab_err, wstrb_err;
    bit  done;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int count_tr(input logic w, input logic [31:0] addr);
        int n = 0;
        foreach (tr_q[i]) if (tr_q[i][64] == w && tr_q[i][63:32] == addr) n++;
        return n;
    endfunction

    // Starts one job, then plays the peripheral until a result appears (or the abort address shows up)
    task automatic run_job(input bit use_b, input logic [1:0] ks);
        int stall;
        logic [64:0] hold;
        tr_q.delete();
        poll_n = 0; stab_err = 0; wstrb_err = 0; done = 1'b0; stall = 0; hold = '0;
        sel = use_b; pt = PT; key = KEY; key_sel = ks;
        @(negedge clk);
        if (use_b) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
        @(negedge clk);
        pt = ~PT; key = ~KEY; key_sel = ~ks;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            ready = 1'b0; error = 1'b0; rdata = '0;
            if (m_res_valid) begin
                done = 1'b1;
            end else if (m_valid) begin
                if (cfg_abort_addr >= 0 && m_write && m_addr == 32'(cfg_abort_addr)) begin
                    done = 1'b1;
                end else begin
                    if (stall == 0) hold = {m_write, m_addr, m_wdata};
                    else if ({m_write, m_addr, m_wdata} !== hold) stab_err++;
                    if (stall < cfg_wait) begin
                        stall++;
                    end else begin
                        stall = 0;
                        ready = 1'b1;
                        tr_q.push_back({m_write, m_addr, m_wdata});
                        if (m_write && m_wstrb !== 4'hF) wstrb_err++;
                        if (!m_write && m_addr == 32'h2C) begin
                            poll_n++;
                            rdata = (cfg_poll_ok != 0 && poll_n >= cfg_poll_ok) ? 32'd1 : 32'd0;
                        end else if (!m_write && m_addr >= 32'h30 && m_addr <= 32'h3C) begin
                            rdata = ct_v[32*int'(m_addr[3:2]) +: 32];
                        end
                        if (m_write && m_addr == 32'(cfg_err_addr)) error = 1'b1;
                    end
                end
            end
            if (!done) @(negedge clk);
        end
        cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
        pt = PT; key = KEY;
        $display("job sel=%0d: %0d transactions, %0d polls, done=%0d", use_b, tr_q.size(), poll_n, done);
        check("job_done", 256'(done), 256'(1));
    endtask

    // Holds the result un-acknowledged for a while, then takes it and expects IDLE
    task automatic finish_job(input int hold_cycles);
        logic [127:0] cap_data;
        logic [1:0]   cap_stat;
        int bad = 0;
        cap_data = m_res_data; cap_stat = m_res_status;
        for (int i = 0; i < hold_cycles; i++) begin
            res_ready = 1'b0;
            if (m_res_valid !== 1'b1 || m_cmd_ready !== 1'b0 || m_res_data !== cap_data
                || m_res_status !== cap_stat || m_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        check("resp_hold_stable", 256'(bad), 256'(0));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("back_to_idle", 256'({m_cmd_ready, m_busy, m_res_valid}), 256'(3'b100));
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; pt = '0; key = '0; key_sel = '0;
        res_ready = 1'b0; rdata = '0; ready = 1'b0; error = 1'b0; sel = 1'b0;
        ct_v = CT;
        exp_w = '{{1'b1, 32'h00, 32'h00000000}, {1'b1, 32'h04, 32'hccddeeff}, {1'b1, 32'h08, 32'h8899aabb},
                  {1'b1, 32'h0C, 32'h44556677}, {1'b1, 32'h10, 32'h00112233}, {1'b1, 32'h14, 32'h14151617},
                  {1'b1, 32'h18, 32'h10111213}, {1'b1, 32'h1C, 32'h0c0d0e0f}, {1'b1, 32'h20, 32'h08090a0b},
                  {1'b1, 32'h24, 32'h04050607}, {1'b1, 32'h28, 32'h00010203}, {1'b1, 32'h80, 32'h00000000},
                  {1'b1, 32'h00, 32'h00000001}};
        #1;
        check("reset_state", 256'({a_valid, a_write, a_addr, a_wdata, a_res_valid, a_res_data,
                                   a_res_status, a_busy, a_cmd_ready}), 256'(1'b1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 AES-192 vector, zero-wait responder, result held back 10 cycles
        cfg_wait = 0; cfg_poll_ok = 1; cfg_err_addr = -1; cfg_abort_addr = -1;
        run_job(1'b0, 2'b00);
        for (int i = 0; i < 13; i++) check($sformatf("j1_write%0d", i), 256'(tr_q[i]), 256'(exp_w[i]));
        check("j1_txn_count", 256'(tr_q.size()), 256'(19));
        check("j1_poll_txn", 256'(tr_q[13]), 256'({1'b0, 32'h2C, 32'h0}));
        for (int i = 0; i < 4; i++)
            check($sformatf("j1_read%0d_addr", i), 256'(tr_q[14+i][64:32]), 256'({1'b0, 32'(48 + 4*i)}));
        check("j1_clear_txn", 256'(tr_q[18]), 256'({1'b1, 32'h00, 32'h0}));
        check("j1_wstrb", 256'(wstrb_err), 256'(0));
        check("j1_res_data", 256'(a_res_data), 256'(128'hdda97ca4864cdfe06eaf70a0ec0d7191));
        check("j1_status", 256'(a_res_status), 256'(2'b00));
        finish_job(10);

        // 3-cycle stall per transaction, ready bit on 5th poll, key bank 2
        cfg_wait = 3; cfg_poll_ok = 5;
        run_job(1'b0, 2'b10);
        check("j2_stall_stable", 256'(stab_err), 256'(0));
        check("j2_txn_count", 256'(tr_q.size()), 256'(23));
        check("j2_poll_reads", 256'(count_tr(1'b0, 32'h2C)), 256'(5));
        check("j2_keysel_write", 256'(tr_q[11]), 256'({1'b1, 32'h80, 32'h2}));
        check("j2_res_data", 256'(a_res_data), 256'(128'hdda97ca4864cdfe06eaf70a0ec0d7191));
        check("j2_status", 256'(a_res_status), 256'(2'b00));
        finish_job(0);

        // bus error on the idx7 write
        cfg_wait = 0; cfg_poll_ok = 1; cfg_err_addr = 32'h1C;
        run_job(1'b0, 2'b00);
        check("j3_txn_count", 256'(tr_q.size()), 256'(8));
        check("j3_last_txn", 256'(tr_q[7]), 256'({1'b1, 32'h1C, 32'h0c0d0e0f}));
        check("j3_status", 256'(a_res_status), 256'(2'b01));
        check("j3_res_data", 256'(a_res_data), 256'(0));
        finish_job(3);

        // POLL_LIMIT = 4 instance, status bit never set
        cfg_err_addr = -1; cfg_poll_ok = 0;
        run_job(1'b1, 2'b00);
        check("j4_poll_reads", 256'(count_tr(1'b0, 32'h2C)), 256'(4));
        check("j4_idx12_reads", 256'(count_tr(1'b0, 32'h30)), 256'(0));
        check("j4_txn_count", 256'(tr_q.size()), 256'(17));
        check("j4_status", 256'(b_res_status), 256'(2'b10));
        finish_job(0);

        // reset pulse during the stalled idx3 write
        cfg_poll_ok = 1; cfg_abort_addr = 32'h0C;
        run_job(1'b0, 2'b00);
        check("rst_pre_valid", 256'({a_valid, a_addr}), 256'({1'b1, 32'h0C}));
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 256'({a_valid, a_write, a_addr, a_wdata, a_busy, a_res_valid}), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", 256'({a_cmd_ready, a_busy}), 256'(2'b10));
        begin
            int act = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (a_valid !== 1'b0 || a_busy !== 1'b0) act++;
            end
            check("rst_no_resume", 256'(act), 256'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/aes_reg_initiator.md
AES_REG_INITIATOR -- requirements
Module: aes_reg_initiator

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, bus address width; DATA_WIDTH, 32, bus data width (only 32 is supported); BASE_ADDR, 0, AES peripheral base address; POLL_LIMIT, 1024, maximum status polls per job.
REQ-002 Ports SHALL be exactly:
- clk_i  in  1  sole clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  job request
- cmd_ready_o  out  1  job accepted when both are high
- pt_i  in  128  plaintext
- key_i  in  192  key
- key_sel_i  in  2  key bank select
- res_valid_o  out  1  result available
- res_ready_i  in  1  result consumed
- res_data_o  out  128  ciphertext
- res_status_o  out  2  00 ok, 01 bus error, 10 timeout
- busy_o  out  1  job in progress
- addr_o  out  ADDR_WIDTH  bus address
- write_o  out  1  1 = write, 0 = read
- wdata_o  out  32  write data
- wstrb_o  out  4  byte strobe
- valid_o  out  1  transaction request
- rdata_i  in  32  read data
- ready_i  in  1  transaction complete
- error_i  in  1  error flag, sampled only at completion

Function
REQ-003 Word index n SHALL map to addr_o = BASE_ADDR + 4*n; wstrb_o SHALL be 4'hF on all writes.
REQ-004 A job SHALL be accepted only in IDLE with cmd_valid_i && cmd_ready_o; cmd_ready_o SHALL equal (state == IDLE); pt_i, key_i and key_sel_i SHALL be registered at acceptance.
REQ-005 After acceptance the block SHALL issue these writes in order:
- idx0 = 0
- idx1..4 = pt[31:0], pt[63:32], pt[95:64], pt[127:96]
- idx5..10 = key[31:0] .. key[191:160], ascending 32-bit slices
- idx32 = {30'b0, key_sel}
- idx0 = 1
REQ-006 A transaction SHALL complete in the cycle where valid_o && ready_i. addr_o, write_o and wdata_o SHALL remain stable while valid_o is high and not yet completed. Only one transaction SHALL be outstanding. The next transaction MAY begin in the cycle after completion.
REQ-007 POLL state: the block SHALL read idx11. If rdata_i[0] == 1, it SHALL go to READ. Otherwise it SHALL increment the poll counter and reissue the read. When the counter reaches POLL_LIMIT with no valid bit seen, it SHALL finish with status 10.
REQ-008 READ state: the block SHALL read idx12..15 into res_data[31:0], [63:32], [95:64], [127:96] respectively.
REQ-009 CLEAR state: the block SHALL write idx0 = 0, then enter RESP with status 00.
REQ-010 If error_i is high at any completion, the block SHALL abandon the remaining sequence, issue no cleanup write, and enter RESP with status 01. res_data_o SHALL hold the words read so far, with unread words equal to 0.
REQ-011 State machine transitions SHALL be:
- IDLE -> WRITE on acceptance
- WRITE -> POLL after the 13th write
- POLL -> READ | RESP
- READ -> CLEAR | RESP
- CLEAR -> RESP
- RESP -> IDLE on res_valid_o && res_ready_i
REQ-012 res_valid_o SHALL be high only in RESP. res_data_o and res_status_o SHALL be stable while res_valid_o is high.
REQ-013 busy_o SHALL be high in every state other than IDLE.
REQ-014 res_data_o SHALL be cleared at acceptance of each new job.
REQ-015 The poll counter SHALL be $clog2(POLL_LIMIT+1) bits wide, SHALL be cleared at acceptance, and SHALL saturate (never wrap).
REQ-016 cmd_valid_i while the block is busy SHALL be ignored (not queued).

Reset
REQ-017 While rst_ni is low, the following SHALL be forced immediately, without waiting for a clock edge:
- state = IDLE
- valid_o = 0, write_o = 0
- addr_o = 0, wdata_o = 0
- res_valid_o = 0, res_data_o = 0, res_status_o = 00
- busy_o = 0
- poll counter = 0
REQ-018 Reset asserted mid-transaction SHALL drop valid_o regardless of ready_i. After release the block SHALL be in IDLE with cmd_ready_o = 1 and SHALL NOT resume the aborted job.

Verification
REQ-019 FIPS-197 AES-192 vector, zero-wait responder:
- stimulus: key 000102030405060708090a0b0c0d0e0f1011121314151617, pt 00112233445566778899aabbccddeeff, key_sel 0
- required: 13 writes in REQ-005 order, with idx5 = 32'h14151617 and idx10 = 32'h00010203
- required: res_data_o = dda97ca4864cdfe06eaf70a0ec0d7191, status 00
REQ-020 Responder with ready_i delayed 3 cycles per transaction: addr_o, write_o and wdata_o SHALL be stable for the full stall and the result SHALL match REQ-019; status valid appears on the 5th poll -> exactly 5 idx11 reads.
REQ-021 POLL_LIMIT = 4 with the status bit never set -> exactly 4 idx11 reads, no idx12 read, status 10.
REQ-022 error_i = 1 on the idx7 write -> no further bus transactions, status 01, res_data_o = 0.
REQ-023 rst_ni pulsed low for 1 cycle during the idx3 write with ready_i held low:
- required: valid_o = 0 within that cycle
- required: after release, cmd_ready_o = 1 and no bus activity until a new cmd_valid_i
REQ-024 res_ready_i held low for 10 cycles -> res_valid_o and res_data_o stable throughout, and cmd_ready_o = 0 throughout.
